// File: rtl/cmp2_pkg.sv
// Shared types and helpers for the digit-serial two-function magnitude comparator.
package cmp2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    LT = 2'd1,
    GT = 2'd2
  } dec_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/cmp2_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice pair.
module cmp2_digit
  import cmp2_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  output dec_t             dec
);

  always_comb begin
    dec = EQ;
    if (a_dig < b_dig)      dec = LT;
    else if (a_dig > b_dig) dec = GT;
  end

endmodule

// File: rtl/cmp2_serial.sv
// Digit-serial LT_LE / GE_GT comparator with valid/ready request and result channels.
//   state | meaning
//   IDLE  | ready for a request, no result pending
//   RUN   | scanning digits MSB-first, NDIG cycles
//   DONE  | result held on lt_le/ge_gt until out_ready
module cmp2_serial
  import cmp2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             leq,
  input  logic             tc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt_le,
  output logic             ge_gt,
  output logic             busy
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("cmp2_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  dec_t             dec_q, dec_d, dig_dec, dec_next;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             leq_q, leq_d;
  logic             lt_le_q, lt_le_d;
  logic             ge_gt_q, ge_gt_d;

  // Operands shift left each RUN cycle so the digit under test is always the top slice.
  cmp2_digit #(.DIGIT(DIGIT)) u_digit (
    .a_dig (a_q[WIDTH-1 -: DIGIT]),
    .b_dig (b_q[WIDTH-1 -: DIGIT]),
    .dec   (dig_dec)
  );

  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    leq_d    = leq_q;
    lt_le_d  = lt_le_q;
    ge_gt_d  = ge_gt_q;
    dec_next = (dec_q == EQ) ? dig_dec : dec_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          // Offset-binary: flipping both MSBs turns a signed compare into an unsigned one.
          if (tc) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          leq_d   = leq;
          cnt_d   = '0;
          dec_d   = EQ;
          state_d = RUN;
        end
      end
      RUN: begin
        dec_d = dec_next;
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          case (dec_next)
            LT:      begin lt_le_d = 1'b1;  ge_gt_d = 1'b0;   end
            GT:      begin lt_le_d = 1'b0;  ge_gt_d = 1'b1;   end
            default: begin lt_le_d = leq_q; ge_gt_d = ~leq_q; end
          endcase
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          lt_le_d = 1'b0;
          ge_gt_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= EQ;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      leq_q   <= 1'b0;
      lt_le_q <= 1'b0;
      ge_gt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      leq_q   <= leq_d;
      lt_le_q <= lt_le_d;
      ge_gt_q <= ge_gt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign lt_le     = lt_le_q;
  assign ge_gt     = ge_gt_q;

endmodule

// File: tb/tb_cmp2_serial.sv
// Scenario bench for cmp2_serial (WIDTH=8, DIGIT=2) with a result scoreboard queue.
module tb_cmp2_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       leq, tc;
  logic       out_valid;
  logic       out_ready;
  logic       lt_le, ge_gt, busy;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  cmp2_serial #(.WIDTH(8), .DIGIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .leq       (leq),
    .tc        (tc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt_le     (lt_le),
    .ge_gt     (ge_gt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic ref_lt_le(input logic [7:0] ra, input logic [7:0] rb,
                                     input logic rleq, input logic rtc);
    logic lt, eq;
    if (rtc) lt = ($signed(ra) < $signed(rb));
    else     lt = (ra < rb);
    eq = (ra == rb);
    return lt | (rleq & eq);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transaction with out_ready high; exp is the required lt_le.
  task automatic run_one(input string name, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ileq, input logic itc, input logic exp);
    int   cyc;
    logic e;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    a = ia; b = ib; leq = ileq; tc = itc; in_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles want 4", name, cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (lt_le !== e || ge_gt !== ~e) begin
      errors++;
      $display("FAIL %s_result: got lt_le=%b ge_gt=%b want lt_le=%b ge_gt=%b",
               name, lt_le, ge_gt, e, ~e);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || lt_le !== 1'b0 || ge_gt !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: got out_valid=%b in_ready=%b lt_le=%b ge_gt=%b want 0 1 0 0",
               name, out_valid, in_ready, lt_le, ge_gt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; leq = 1'b0; tc = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || lt_le !== 1'b0 || ge_gt !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got in_ready=%b out_valid=%b lt_le=%b ge_gt=%b busy=%b want 1 0 0 0 0",
               in_ready, out_valid, lt_le, ge_gt, busy);
    end
  endtask

  task automatic test_unsigned();
    run_one("unsigned_lt", 8'h05, 8'h0A, 1'b0, 1'b0, 1'b1);
    run_one("unsigned_gt", 8'hC3, 8'h3C, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    run_one("signed_ff_01",   8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
    run_one("unsigned_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_one("signed_80_7f",   8'h80, 8'h7F, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_equality();
    run_one("eq_leq1",     8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
    run_one("eq_leq0",     8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    run_one("msb_digit",   8'h40, 8'h3F, 1'b1, 1'b0, 1'b0);
    run_one("lsb_digit",   8'h3E, 8'h3F, 1'b0, 1'b0, 1'b1);
    run_one("eq_signed",   8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic e;
    out_ready = 1'b0;
    a = 8'h22; b = 8'h21; leq = 1'b0; tc = 1'b0; in_valid = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); leq = 1'($urandom); tc = 1'($urandom);
      in_valid = ~in_valid;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || lt_le !== e || ge_gt !== ~e || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got out_valid=%b in_ready=%b lt_le=%b ge_gt=%b busy=%b want 1 0 %b %b 1",
                 i, out_valid, in_ready, lt_le, ge_gt, busy, e, ~e);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || lt_le !== 1'b0 || ge_gt !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got out_valid=%b in_ready=%b lt_le=%b ge_gt=%b want 0 1 0 0",
               out_valid, in_ready, lt_le, ge_gt);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    out_ready = 1'b1;
    a = 8'h05; b = 8'h0A; leq = 1'b0; tc = 1'b0; in_valid = 1'b1;
    exp_q.push_back(1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || lt_le !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got in_ready=%b out_valid=%b busy=%b lt_le=%b want 1 0 0 0",
               in_ready, out_valid, busy, lt_le);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrun_no_pulse: got %0d out_valid cycles want 0", pulses);
    end
    run_one("after_reset", 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_throughput();
    int   accepts, results, cycle, last_acc, budget;
    logic e, acc_now;
    accepts = 0; results = 0; cycle = 0; last_acc = -1;
    budget = 1000 * 6 + 100;
    out_ready = 1'b1;
    a = 8'($urandom); b = 8'($urandom); leq = 1'($urandom); tc = 1'($urandom);
    in_valid = 1'b1;
    while ((results < 1000) && (cycle < budget)) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tput_unexpected: got result with empty scoreboard at cycle %0d", cycle);
        end else begin
          e = exp_q.pop_front();
          if (lt_le !== e || ge_gt !== ~e) begin
            errors++;
            $display("FAIL tput_result%0d: got lt_le=%b ge_gt=%b want %b %b",
                     results, lt_le, ge_gt, e, ~e);
          end
        end
        results++;
      end
      acc_now = (in_ready === 1'b1) && (accepts < 1000);
      in_valid = (accepts < 1000);
      if (acc_now) begin
        exp_q.push_back(ref_lt_le(a, b, leq, tc));
        if (last_acc >= 0) begin
          checks++;
          if (cycle - last_acc != 6) begin
            errors++;
            $display("FAIL tput_period: got %0d cycles want 6", cycle - last_acc);
          end
        end
        last_acc = cycle;
        accepts++;
      end
      tick();
      cycle++;
      if (acc_now) begin
        a = 8'($urandom); b = 8'($urandom); leq = 1'($urandom); tc = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (results != 1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tput_count: got %0d results, %0d pending want 1000, 0", results, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_equality();
    test_backpressure();
    test_reset_mid_run();
    test_throughput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
